// File: rtl/phase1_sequencer.sv
// phase1_sequencer
//   Registered control sequencer for the phase-1 force/velocity pass. Reduces the
//   per-cell status vectors under a live enable mask, registers the reduced flags,
//   and walks IDLE -> LOAD -> HOLD -> RUN (-> LOAD ...) -> DRAIN -> DONE while
//   counting batches and guarding RUN/DRAIN with a watchdog.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   CTL_READY           : start request (level), also releases DONE when low
//   CTL_DOUBLE_BUFFER   : buffer select, latched at start into buffer_sel
//   CTL_DONE            : high while in DONE
//   cell_mask           : 1 = cell participates
//   done_batch/done_all : per-cell batch / all-batches finished
//   in_flight           : per-cell particles still in the ring
//   pipeline_done       : per-cell compute pipeline drained
//   v_rempty            : per-cell velocity ring empty
//   dispatch            : 00 idle, 01 load batch, 10 shift ring
//   buffer_sel          : latched buffer select
//   batch_count         : batches completed this pass (saturating)
//   busy                : state is neither IDLE nor DONE
//   err                 : watchdog expired this pass (sticky until next start)

module phase1_sequencer #(
    parameter int unsigned N_CELL  = 27,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned BATCH_W = 16,
    parameter int unsigned WAIT_W  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CTL_READY,
    input  logic               CTL_DOUBLE_BUFFER,
    output logic               CTL_DONE,
    input  logic [N_CELL-1:0]  cell_mask,
    input  logic [N_CELL-1:0]  done_batch,
    input  logic [N_CELL-1:0]  done_all,
    input  logic [N_CELL-1:0]  in_flight,
    input  logic [N_CELL-1:0]  pipeline_done,
    input  logic [N_CELL-1:0]  v_rempty,
    output logic [1:0]         dispatch,
    output logic               buffer_sel,
    output logic [BATCH_W-1:0] batch_count,
    output logic               busy,
    output logic               err
);

    localparam int unsigned SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHold,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic               r_fin_batch;
    logic               r_fin_all;
    logic               r_infl;
    logic               r_drained;
    logic [SET_W-1:0]   r_settle;
    logic [WAIT_W-1:0]  r_wd;
    logic               r_buffer_sel;
    logic [BATCH_W-1:0] r_batch_count;
    logic               r_err;

    logic w_fin_batch;
    logic w_fin_all;
    logic w_infl;
    logic w_drained;
    logic w_run_exit;
    logic w_wd_expired;
    logic w_wd_active;

    // Masked-off cells read as done and not in flight.
    assign w_fin_batch = &(done_batch | ~cell_mask);
    assign w_fin_all   = &(done_all | ~cell_mask);
    assign w_infl      = |(in_flight & cell_mask);
    assign w_drained   = &((pipeline_done & v_rempty) | ~cell_mask);

    assign w_run_exit   = r_fin_batch && !r_infl;
    assign w_wd_expired = &r_wd;
    assign w_wd_active  = (r_state == StRun) || (r_state == StDrain);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Normal exits are tested before the watchdog so they win a tie.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (CTL_READY) begin
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_state_next = StHold;
            end
            StHold: begin
                if (r_settle == SET_W'(1)) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_run_exit) begin
                    w_state_next = r_fin_all ? StDrain : StLoad;
                end else if (w_wd_expired) begin
                    w_state_next = StDone;
                end
            end
            StDrain: begin
                if (r_drained || w_wd_expired) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (!CTL_READY) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        dispatch = 2'b00;
        CTL_DONE = 1'b0;
        busy     = 1'b0;
        unique case (r_state)
            StIdle:  ;
            StLoad:  begin dispatch = 2'b01; busy = 1'b1; end
            StHold:  busy = 1'b1;
            StRun:   begin dispatch = 2'b10; busy = 1'b1; end
            StDrain: busy = 1'b1;
            StDone:  CTL_DONE = 1'b1;
            default: ;
        endcase
    end

    // Flag registers, settle/watchdog counters and pass bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fin_batch   <= 1'b0;
            r_fin_all     <= 1'b0;
            r_infl        <= 1'b0;
            r_drained     <= 1'b0;
            r_settle      <= '0;
            r_wd          <= '0;
            r_buffer_sel  <= 1'b0;
            r_batch_count <= '0;
            r_err         <= 1'b0;
        end else begin
            r_fin_batch <= w_fin_batch;
            r_fin_all   <= w_fin_all;
            r_infl      <= w_infl;
            r_drained   <= w_drained;

            if (r_state == StLoad) begin
                r_settle <= SETTLE_INIT;
            end else if (r_state == StHold) begin
                r_settle <= r_settle - SET_W'(1);
            end

            // Counts only while parked in RUN or DRAIN; any transition restarts it.
            if ((w_state_next != r_state) || !w_wd_active) begin
                r_wd <= '0;
            end else begin
                r_wd <= r_wd + WAIT_W'(1);
            end

            if ((r_state == StIdle) && CTL_READY) begin
                r_buffer_sel  <= CTL_DOUBLE_BUFFER;
                r_batch_count <= '0;
                r_err         <= 1'b0;
            end

            if ((r_state == StRun) && w_run_exit && !(&r_batch_count)) begin
                r_batch_count <= r_batch_count + BATCH_W'(1);
            end

            if (((r_state == StRun) && !w_run_exit && w_wd_expired) ||
                ((r_state == StDrain) && !r_drained && w_wd_expired)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign buffer_sel  = r_buffer_sel;
    assign batch_count = r_batch_count;
    assign err         = r_err;

endmodule

// File: tb/tb_phase1_sequencer.sv
// Bench for phase1_sequencer with N_CELL=4, SETTLE=2, WAIT_W=4. Inputs change on the
// falling edge; outputs are sampled on the falling edge. Each pass pushes its expected
// end-of-pass result to a queue, popped when CTL_DONE appears.

module tb_phase1_sequencer;

    localparam int unsigned N_CELL  = 4;
    localparam int unsigned BATCH_W = 16;

    logic               clk;
    logic               reset;
    logic               CTL_READY;
    logic               CTL_DOUBLE_BUFFER;
    logic               CTL_DONE;
    logic [N_CELL-1:0]  cell_mask;
    logic [N_CELL-1:0]  done_batch;
    logic [N_CELL-1:0]  done_all;
    logic [N_CELL-1:0]  in_flight;
    logic [N_CELL-1:0]  pipeline_done;
    logic [N_CELL-1:0]  v_rempty;
    logic [1:0]         dispatch;
    logic               buffer_sel;
    logic [BATCH_W-1:0] batch_count;
    logic               busy;
    logic               err;

    typedef struct packed {
        logic [BATCH_W-1:0] bc;
        logic               err;
        logic               bsel;
    } exp_t;

    exp_t       sb_q[$];
    logic [1:0] disp_q[$];
    int         total = 0;
    int         bad   = 0;

    phase1_sequencer #(
        .N_CELL (N_CELL),
        .SETTLE (2),
        .BATCH_W(BATCH_W),
        .WAIT_W (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .CTL_READY        (CTL_READY),
        .CTL_DOUBLE_BUFFER(CTL_DOUBLE_BUFFER),
        .CTL_DONE         (CTL_DONE),
        .cell_mask        (cell_mask),
        .done_batch       (done_batch),
        .done_all         (done_all),
        .in_flight        (in_flight),
        .pipeline_done    (pipeline_done),
        .v_rempty         (v_rempty),
        .dispatch         (dispatch),
        .buffer_sel       (buffer_sel),
        .batch_count      (batch_count),
        .busy             (busy),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        done_batch    = '0;
        done_all      = '0;
        in_flight     = '0;
        pipeline_done = '0;
        v_rempty      = '0;
    endtask

    // Waits for CTL_DONE within budget cycles, then checks it against the queued result.
    task automatic sb_wait_done(input int budget, input string tag);
        int   n = 0;
        exp_t e;
        while (!CTL_DONE && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (CTL_DONE !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout: CTL_DONE=%b after %0d cycles, required 1",
                     tag, CTL_DONE, n);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s_no_expect: CTL_DONE seen with empty scoreboard", tag);
        end else begin
            e = sb_q.pop_front();
            total++;
            if (batch_count !== e.bc) begin
                bad++;
                $display("FAIL %s_batch_count: got %0d, required %0d", tag, batch_count, e.bc);
            end
            total++;
            if (err !== e.err) begin
                bad++;
                $display("FAIL %s_err: got %b, required %b", tag, err, e.err);
            end
            total++;
            if (buffer_sel !== e.bsel) begin
                bad++;
                $display("FAIL %s_buffer_sel: got %b, required %b", tag, buffer_sel, e.bsel);
            end
        end
    endtask

    task automatic test_reset;
        total++;
        if ({dispatch, CTL_DONE, buffer_sel, batch_count, busy, err} !== '0) begin
            bad++;
            $display("FAIL reset_values: disp=%b done=%b bsel=%b bc=%0d busy=%b err=%b, required all 0",
                     dispatch, CTL_DONE, buffer_sel, batch_count, busy, err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_batches;
        cell_mask = 4'b1111;
        CTL_DOUBLE_BUFFER = 1'b0;
        CTL_READY = 1'b1;
        in_flight = 4'b0001;
        sb_q.push_back('{bc: 16'd2, err: 1'b0, bsel: 1'b0});
        tick();
        total++;
        if (dispatch !== 2'b01 || busy !== 1'b1) begin
            bad++;
            $display("FAIL batch_load: disp=%b busy=%b, required 01/1", dispatch, busy);
        end
        tick();
        tick();
        total++;
        if (dispatch !== 2'b00) begin
            bad++;
            $display("FAIL batch_hold: disp=%b, required 00", dispatch);
        end
        tick();
        total++;
        if (dispatch !== 2'b10) begin
            bad++;
            $display("FAIL batch_run_entry: disp=%b, required 10", dispatch);
        end
        repeat (4) tick();
        total++;
        if (dispatch !== 2'b10) begin
            bad++;
            $display("FAIL batch_inflight_stall: disp=%b, required 10", dispatch);
        end
        done_batch = 4'b1111;
        in_flight  = 4'b0000;
        tick();
        total++;
        if (dispatch !== 2'b10) begin
            bad++;
            $display("FAIL batch_flag_latency: disp=%b, required 10", dispatch);
        end
        tick();
        total++;
        if (dispatch !== 2'b01 || batch_count !== 16'd1) begin
            bad++;
            $display("FAIL batch_reload: disp=%b bc=%0d, required 01/1", dispatch, batch_count);
        end
        done_batch = 4'b0000;
        repeat (3) tick();
        total++;
        if (dispatch !== 2'b10) begin
            bad++;
            $display("FAIL batch2_run: disp=%b, required 10", dispatch);
        end
        done_batch = 4'b1111;
        done_all   = 4'b1111;
        tick();
        tick();
        total++;
        if (dispatch !== 2'b00 || busy !== 1'b1 || CTL_DONE !== 1'b0 || batch_count !== 16'd2) begin
            bad++;
            $display("FAIL batch_drain: disp=%b busy=%b done=%b bc=%0d, required 00/1/0/2",
                     dispatch, busy, CTL_DONE, batch_count);
        end
        repeat (2) tick();
        pipeline_done = 4'b1111;
        v_rempty      = 4'b1111;
        tick();
        total++;
        if (CTL_DONE !== 1'b0) begin
            bad++;
            $display("FAIL drain_latency: CTL_DONE=%b, required 0", CTL_DONE);
        end
        sb_wait_done(4, "batches");
        tick();
        total++;
        if (CTL_DONE !== 1'b1) begin
            bad++;
            $display("FAIL done_hold: CTL_DONE=%b with READY high, required 1", CTL_DONE);
        end
        CTL_READY = 1'b0;
        tick();
        total++;
        if (CTL_DONE !== 1'b0 || busy !== 1'b0 || dispatch !== 2'b00) begin
            bad++;
            $display("FAIL done_release: done=%b busy=%b disp=%b, required 0/0/00",
                     CTL_DONE, busy, dispatch);
        end
        clear_inputs();
    endtask

    task automatic test_mask;
        cell_mask     = 4'b1011;
        in_flight     = 4'b0100;
        done_batch    = 4'b1011;
        done_all      = 4'b1011;
        pipeline_done = 4'b1011;
        v_rempty      = 4'b1011;
        tick();
        CTL_READY = 1'b1;
        sb_q.push_back('{bc: 16'd1, err: 1'b0, bsel: 1'b0});
        sb_wait_done(12, "mask");
        CTL_READY = 1'b0;
        tick();
        clear_inputs();
        cell_mask = 4'b1111;
    endtask

    task automatic test_double_buffer;
        CTL_DOUBLE_BUFFER = 1'b1;
        CTL_READY = 1'b1;
        sb_q.push_back('{bc: 16'd1, err: 1'b0, bsel: 1'b1});
        tick();
        total++;
        if (buffer_sel !== 1'b1) begin
            bad++;
            $display("FAIL dbuf_latch: buffer_sel=%b, required 1", buffer_sel);
        end
        CTL_DOUBLE_BUFFER = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            CTL_DOUBLE_BUFFER = ~CTL_DOUBLE_BUFFER;
            tick();
            total++;
            if (buffer_sel !== 1'b1 || dispatch !== 2'b10) begin
                bad++;
                $display("FAIL dbuf_run_%0d: buffer_sel=%b disp=%b, required 1/10",
                         i, buffer_sel, dispatch);
            end
        end
        done_batch    = 4'b1111;
        done_all      = 4'b1111;
        pipeline_done = 4'b1111;
        v_rempty      = 4'b1111;
        sb_wait_done(10, "dbuf");
        CTL_READY = 1'b0;
        CTL_DOUBLE_BUFFER = 1'b0;
        tick();
        clear_inputs();
    endtask

    task automatic test_watchdog;
        clear_inputs();
        CTL_READY = 1'b1;
        sb_q.push_back('{bc: 16'd0, err: 1'b1, bsel: 1'b0});
        repeat (4) tick();
        total++;
        if (dispatch !== 2'b10) begin
            bad++;
            $display("FAIL wd_run_entry: disp=%b, required 10", dispatch);
        end
        for (int k = 2; k <= 16; k++) begin
            tick();
            total++;
            if (dispatch !== 2'b10 || err !== 1'b0) begin
                bad++;
                $display("FAIL wd_run_cycle_%0d: disp=%b err=%b, required 10/0", k, dispatch, err);
            end
        end
        tick();
        sb_wait_done(0, "watchdog");
        tick();
        total++;
        if (CTL_DONE !== 1'b1) begin
            bad++;
            $display("FAIL wd_done_hold: CTL_DONE=%b, required 1", CTL_DONE);
        end
        CTL_READY = 1'b0;
        tick();
        total++;
        if (err !== 1'b1 || CTL_DONE !== 1'b0) begin
            bad++;
            $display("FAIL wd_err_sticky: err=%b done=%b in IDLE, required 1/0", err, CTL_DONE);
        end
        CTL_READY = 1'b1;
        CTL_DOUBLE_BUFFER = 1'b1;
        tick();
        total++;
        if (err !== 1'b0 || dispatch !== 2'b01) begin
            bad++;
            $display("FAIL wd_err_clear: err=%b disp=%b, required 0/01", err, dispatch);
        end
    endtask

    // Continues the pass started at the end of test_watchdog.
    task automatic test_reset_mid_run;
        repeat (3) tick();
        total++;
        if (dispatch !== 2'b10 || buffer_sel !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_run: disp=%b bsel=%b, required 10/1", dispatch, buffer_sel);
        end
        reset = 1'b1;
        CTL_READY = 1'b0;
        CTL_DOUBLE_BUFFER = 1'b0;
        tick();
        total++;
        if ({dispatch, CTL_DONE, buffer_sel, batch_count, busy, err} !== '0) begin
            bad++;
            $display("FAIL rst_mid_run: disp=%b done=%b bsel=%b bc=%0d busy=%b err=%b, required all 0",
                     dispatch, CTL_DONE, buffer_sel, batch_count, busy, err);
        end
        reset = 1'b0;
    endtask

    task automatic test_mask_zero;
        logic [1:0] exp_d;
        cell_mask = 4'b0000;
        tick();
        CTL_READY = 1'b1;
        disp_q.push_back(2'b01);
        disp_q.push_back(2'b00);
        disp_q.push_back(2'b00);
        disp_q.push_back(2'b10);
        disp_q.push_back(2'b00);
        sb_q.push_back('{bc: 16'd1, err: 1'b0, bsel: 1'b0});
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_d = disp_q.pop_front();
            total++;
            if (dispatch !== exp_d || CTL_DONE !== 1'b0) begin
                bad++;
                $display("FAIL mask0_seq_%0d: disp=%b done=%b, required %b/0",
                         i, dispatch, CTL_DONE, exp_d);
            end
        end
        tick();
        sb_wait_done(0, "mask0");
        CTL_READY = 1'b0;
        tick();
        total++;
        if (CTL_DONE !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mask0_release: done=%b busy=%b, required 0/0", CTL_DONE, busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        CTL_READY = 1'b0;
        CTL_DOUBLE_BUFFER = 1'b0;
        cell_mask = 4'b1111;
        clear_inputs();
        tick();
        tick();
        test_reset();
        test_batches();
        test_mask();
        test_double_buffer();
        test_watchdog();
        test_reset_mid_run();
        test_mask_zero();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
